// File: rtl/mc_control_fsm.sv
// Multi-cycle control FSM for the MIPS-subset core.
// Moore decode of the datapath controls from the current state, with the
// fetch strobes gated by memory readiness. Memory states optionally wait on
// mem_ready with a bounded wait. The FSM traps on an undefined opcode or a
// memory timeout, and it counts retired instructions.
module mc_control_fsm #(
  parameter int HANDSHAKE      = 1,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 pc_write_cond_ne,
  output logic                 iord,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           mem_to_reg,
  output logic [1:0]           reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           pc_source,
  output logic                 illegal_op,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JAL       = 4'd12,
    S_TRAP      = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  // The wait counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int                  WC_W    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WC_W-1:0]     WC_LAST = WC_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [WC_W-1:0]     WC_ONE  = WC_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t              r_state;
  logic [WC_W-1:0]     r_wait_cnt;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                r_illegal_op;
  logic                r_bus_error;
  logic                r_is_bne;
  logic                r_is_load;

  logic                w_rdy;
  logic                w_mem_state;
  logic                w_timeout;

  assign w_rdy       = (HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // A completing access in the last allowed cycle wins over the timeout.
  assign w_timeout   = (TIMEOUT_CYCLES != 0) && w_mem_state && !w_rdy && (r_wait_cnt == WC_LAST);

  // State sequencing, sticky trap flags, wait counter and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_wait_cnt   <= '0;
      r_retired    <= '0;
      r_illegal_op <= 1'b0;
      r_bus_error  <= 1'b0;
      r_is_bne     <= 1'b0;
      r_is_load    <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:     if (w_rdy) r_state <= S_DECODE;
        S_DECODE: begin
          r_is_bne  <= (opcode == OP_BNE);
          r_is_load <= (opcode == OP_LW);
          case (opcode)
            OP_LW, OP_SW:    r_state <= S_MEM_ADDR;
            OP_R:            r_state <= S_R_EXEC;
            OP_BEQ, OP_BNE:  r_state <= S_BRANCH;
            OP_J:            r_state <= S_JUMP;
            OP_JAL:          r_state <= S_JAL;
            OP_ADDI:         r_state <= S_ADDI_EXEC;
            default: begin
              r_state      <= S_TRAP;
              r_illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR:  r_state <= r_is_load ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:    if (w_rdy) r_state <= S_MEM_WB;
        S_MEM_WR: begin
          if (w_rdy) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNT_ONE;
          end
        end
        S_R_EXEC:    r_state <= S_R_WB;
        S_ADDI_EXEC: r_state <= S_ADDI_WB;
        S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB, S_JAL: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_ONE;
        end
        S_TRAP:      r_state <= S_TRAP;
        default:     r_state <= S_TRAP;
      endcase

      if (w_timeout) begin
        r_state     <= S_TRAP;
        r_bus_error <= 1'b1;
      end

      if (!w_mem_state || w_rdy || w_timeout) r_wait_cnt <= '0;
      else                                    r_wait_cnt <= r_wait_cnt + WC_ONE;
    end
  end

  // Control decode from state; everything is forced low while reset is held.
  always_comb begin
    pc_write         = 1'b0;
    pc_write_cond    = 1'b0;
    pc_write_cond_ne = 1'b0;
    iord             = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    mem_to_reg       = 2'b00;
    reg_dst          = 2'b00;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    alu_op           = 2'b00;
    pc_source        = 2'b00;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = w_rdy;
          pc_write  = w_rdy;
        end
        S_DECODE:    alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
        end
        S_BRANCH: begin
          alu_src_a        = 1'b1;
          alu_op           = 2'b01;
          pc_source        = 2'b01;
          pc_write_cond    = !r_is_bne;
          pc_write_cond_ne = r_is_bne;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_ADDI_WB:   reg_write = 1'b1;
        S_JAL: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign illegal_op = r_illegal_op;
  assign bus_error  = r_bus_error;
  assign retired    = r_retired;
  assign state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (handshake with short timeout;
// no handshake with a 4-bit counter) checked against an instruction-level
// model that tracks each instruction as a list of control steps.
`timescale 1ns/1ps
module tb_mc_control_fsm;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Instance A: HANDSHAKE=1, TIMEOUT_CYCLES=4, CNT_WIDTH=32
  logic        rst_a, mr_a;
  logic [5:0]  opc_a;
  logic        pcw_a, pcc_a, pcne_a, iord_a, mrd_a, mwr_a, irw_a, rw_a, asa_a, ill_a, berr_a;
  logic [1:0]  m2r_a, rdst_a, asb_a, aop_a, psrc_a;
  logic [31:0] ret_a;
  logic [3:0]  st_a;
  logic [18:0] ctl_a;

  // Instance B: HANDSHAKE=0, TIMEOUT_CYCLES=255, CNT_WIDTH=4
  logic        rst_b, mr_b;
  logic [5:0]  opc_b;
  logic        pcw_b, pcc_b, pcne_b, iord_b, mrd_b, mwr_b, irw_b, rw_b, asa_b, ill_b, berr_b;
  logic [1:0]  m2r_b, rdst_b, asb_b, aop_b, psrc_b;
  logic [3:0]  ret_b;
  logic [3:0]  st_b;
  logic [18:0] ctl_b;

  assign ctl_a = {pcw_a, pcc_a, pcne_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, rdst_a, rw_a, asa_a, asb_a, aop_a, psrc_a};
  assign ctl_b = {pcw_b, pcc_b, pcne_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, rdst_b, rw_b, asa_b, asb_b, aop_b, psrc_b};

  mc_control_fsm #(.HANDSHAKE(1), .TIMEOUT_CYCLES(4), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .reset(rst_a), .opcode(opc_a), .mem_ready(mr_a),
    .pc_write(pcw_a), .pc_write_cond(pcc_a), .pc_write_cond_ne(pcne_a), .iord(iord_a),
    .mem_read(mrd_a), .mem_write(mwr_a), .ir_write(irw_a), .mem_to_reg(m2r_a), .reg_dst(rdst_a),
    .reg_write(rw_a), .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a), .pc_source(psrc_a),
    .illegal_op(ill_a), .bus_error(berr_a), .retired(ret_a), .state(st_a));

  mc_control_fsm #(.HANDSHAKE(0), .TIMEOUT_CYCLES(255), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(rst_b), .opcode(opc_b), .mem_ready(mr_b),
    .pc_write(pcw_b), .pc_write_cond(pcc_b), .pc_write_cond_ne(pcne_b), .iord(iord_b),
    .mem_read(mrd_b), .mem_write(mwr_b), .ir_write(irw_b), .mem_to_reg(m2r_b), .reg_dst(rdst_b),
    .reg_write(rw_b), .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b), .pc_source(psrc_b),
    .illegal_op(ill_b), .bus_error(berr_b), .retired(ret_b), .state(st_b));

  // ---------------- reference model ----------------
  int               HS [2] = '{1, 0};
  int               TO [2] = '{4, 255};
  logic [63:0]      RMASK [2] = '{64'hFFFF_FFFF, 64'hF};
  logic [18:0]      tbl [14];
  localparam logic [18:0] FETCH_GO = 19'h41000;   // pc_write | ir_write
  localparam logic [18:0] COND_EQ  = 19'h20000;
  localparam logic [18:0] COND_NE  = 19'h10000;

  int          m_seq [2][6];
  int          m_pos [2];
  int          m_len [2];
  int          m_wait [2];
  bit          m_trap [2];
  bit          m_ill [2];
  bit          m_berr [2];
  bit          m_bne [2];
  logic [63:0] m_ret [2];

  logic        cur_rst [2];
  logic [5:0]  cur_opc [2];
  logic        cur_mr [2];

  function automatic logic [18:0] mk(input logic pcw, input logic iord, input logic mrd, input logic mwr,
                                     input logic [1:0] m2r, input logic [1:0] rd, input logic rw,
                                     input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                     input logic [1:0] psrc);
    return {pcw, 1'b0, 1'b0, iord, mrd, mwr, 1'b0, m2r, rd, rw, asa, asb, aop, psrc};
  endfunction

  task automatic model_reset(input int k);
    m_seq[k][0] = 0; m_seq[k][1] = 1;
    m_pos[k] = 0; m_len[k] = 2; m_wait[k] = 0;
    m_trap[k] = 0; m_ill[k] = 0; m_berr[k] = 0; m_bne[k] = 0; m_ret[k] = 64'd0;
  endtask

  task automatic plan(input int k, input int n, input int a, input int b, input int c);
    m_seq[k][2] = a; m_seq[k][3] = b; m_seq[k][4] = c;
    m_len[k] = 2 + n;
  endtask

  // Advance the model by one clock, using the inputs present before the edge.
  task automatic model_step(input int k);
    int   cur;
    logic rdy;
    if (cur_rst[k]) begin model_reset(k); return; end
    if (m_trap[k]) return;
    rdy = (HS[k] != 0) ? cur_mr[k] : 1'b1;
    cur = m_seq[k][m_pos[k]];
    if ((cur == 0 || cur == 3 || cur == 5) && !rdy) begin
      m_wait[k]++;
      if (TO[k] != 0 && m_wait[k] == TO[k]) begin m_trap[k] = 1; m_berr[k] = 1; end
      return;
    end
    m_wait[k] = 0;
    if (cur == 1) begin
      m_bne[k] = (cur_opc[k] == OP_BNE);
      case (cur_opc[k])
        OP_LW:   plan(k, 3, 2, 3, 4);
        OP_SW:   plan(k, 2, 2, 5, 0);
        OP_R:    plan(k, 2, 6, 7, 0);
        OP_BEQ:  plan(k, 1, 8, 0, 0);
        OP_BNE:  plan(k, 1, 8, 0, 0);
        OP_J:    plan(k, 1, 9, 0, 0);
        OP_JAL:  plan(k, 1, 12, 0, 0);
        OP_ADDI: plan(k, 2, 10, 11, 0);
        default: begin m_trap[k] = 1; m_ill[k] = 1; return; end
      endcase
    end
    m_pos[k]++;
    if (m_pos[k] == m_len[k]) begin
      m_ret[k] = m_ret[k] + 64'd1;
      m_pos[k] = 0;
      m_len[k] = 2;
    end
  endtask

  function automatic logic [24:0] expv(input int k);
    int          st;
    logic        rdy;
    logic [18:0] c;
    st  = m_trap[k] ? 13 : m_seq[k][m_pos[k]];
    rdy = (HS[k] != 0) ? cur_mr[k] : 1'b1;
    c   = tbl[st];
    if (st == 0 && rdy) c = c | FETCH_GO;
    if (st == 8) c = c | (m_bne[k] ? COND_NE : COND_EQ);
    if (cur_rst[k]) c = 19'd0;
    return {c, 4'(st), m_ill[k], m_berr[k]};
  endfunction

  function automatic logic [24:0] obs(input int k);
    if (k == 0) return {ctl_a, st_a, ill_a, berr_a};
    return {ctl_b, st_b, ill_b, berr_b};
  endfunction

  function automatic logic [63:0] oret(input int k);
    if (k == 0) return 64'(ret_a);
    return 64'(ret_b);
  endfunction

  function automatic logic [63:0] eret(input int k);
    return m_ret[k] & RMASK[k];
  endfunction

  function automatic logic mrbit(input int v);
    if (v == 2) return 1'($urandom);
    return (v != 0);
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] ops [8];
    int         r;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_ADDI};
    r = $urandom_range(0, 9);
    if (r < 8) return ops[r];
    return 6'($urandom);
  endfunction

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic drive(input int k, input logic rst, input logic [5:0] opc, input logic mr);
    cur_rst[k] = rst; cur_opc[k] = opc; cur_mr[k] = mr;
    if (k == 0) begin rst_a = rst; opc_a = opc; mr_a = mr; end
    else        begin rst_b = rst; opc_b = opc; mr_b = mr; end
    @(negedge clk);
  endtask

  task automatic advance(input int k);
    @(posedge clk);
    model_step(k);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive(0, 1'b1, OP_R, 1'b1);
    checks++; if (ctl_a !== 19'd0) begin errors++; $display("FAIL reset_ctl_a: got %h expected 0", ctl_a); end
    advance(0);
    drive(0, 1'b0, OP_R, 1'b0);
    checks++; if (obs(0) !== expv(0)) begin errors++; $display("FAIL reset_obs_a: got %h expected %h", obs(0), expv(0)); end
    checks++; if ({st_a, ill_a, berr_a, ret_a} !== 38'd0) begin errors++; $display("FAIL reset_state_a: got st=%0d ill=%b berr=%b ret=%0d expected all 0", st_a, ill_a, berr_a, ret_a); end
    advance(0);
    drive(1, 1'b1, OP_R, 1'b0);
    checks++; if (ctl_b !== 19'd0) begin errors++; $display("FAIL reset_ctl_b: got %h expected 0", ctl_b); end
    advance(1);
    drive(1, 1'b0, OP_J, 1'b0);
    checks++; if (obs(1) !== expv(1)) begin errors++; $display("FAIL reset_obs_b: got %h expected %h", obs(1), expv(1)); end
    checks++; if (irw_b !== 1'b1) begin errors++; $display("FAIL nohs_fetch_irw: got %b expected 1", irw_b); end
    advance(1);
  endtask

  task automatic test_lw_wait();
    int mrs [12] = '{0, 0, 0, 1, 2, 2, 0, 0, 0, 1, 2, 0};
    int fetch_cyc = 0, irw_pulses = 0, wb_writes = 0;
    drive(0, 1'b1, OP_LW, 1'b0); advance(0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1'b0, OP_LW, mrbit(mrs[i]));
      checks++; if (obs(0) !== expv(0)) begin errors++; $display("FAIL lw_cyc%0d: got %h expected %h", i, obs(0), expv(0)); end
      checks++; if (oret(0) !== eret(0)) begin errors++; $display("FAIL lw_ret%0d: got %0d expected %0d", i, oret(0), eret(0)); end
      if (i < 11 && st_a == 4'd0) fetch_cyc++;
      if (irw_a === 1'b1) irw_pulses++;
      if (st_a == 4'd4 && rw_a === 1'b1 && m2r_a == 2'b01) wb_writes++;
      advance(0);
    end
    checks++; if (fetch_cyc != 4) begin errors++; $display("FAIL lw_fetch_len: got %0d expected 4", fetch_cyc); end
    checks++; if (irw_pulses != 1) begin errors++; $display("FAIL lw_irw_pulses: got %0d expected 1", irw_pulses); end
    checks++; if (wb_writes != 1) begin errors++; $display("FAIL lw_wb: got %0d expected 1", wb_writes); end
    checks++; if (ret_a !== 32'd1) begin errors++; $display("FAIL lw_retired: got %0d expected 1", ret_a); end
  endtask

  task automatic test_timeout();
    int mrs1 [10] = '{1, 2, 2, 0, 0, 0, 0, 2, 2, 2};
    int mrs2 [8]  = '{1, 2, 2, 0, 0, 0, 1, 0};
    int wr_cyc = 0;
    drive(0, 1'b1, OP_SW, 1'b0); advance(0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'b0, OP_SW, mrbit(mrs1[i]));
      checks++; if (obs(0) !== expv(0)) begin errors++; $display("FAIL tmo_cyc%0d: got %h expected %h", i, obs(0), expv(0)); end
      if (st_a == 4'd5) wr_cyc++;
      advance(0);
    end
    checks++; if (wr_cyc != 4) begin errors++; $display("FAIL tmo_wait: got %0d expected 4", wr_cyc); end
    checks++; if ({st_a, berr_a, ill_a, mwr_a} !== {4'd13, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL tmo_trap: got st=%0d berr=%b ill=%b mw=%b expected st=13 berr=1 ill=0 mw=0", st_a, berr_a, ill_a, mwr_a); end
    drive(0, 1'b1, OP_SW, 1'b0); advance(0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b0, OP_SW, mrbit(mrs2[i]));
      checks++; if (obs(0) !== expv(0)) begin errors++; $display("FAIL tmo_edge%0d: got %h expected %h", i, obs(0), expv(0)); end
      advance(0);
    end
    checks++; if ({st_a, berr_a, ret_a} !== {4'd0, 1'b0, 32'd1}) begin
      errors++; $display("FAIL tmo_last_rdy: got st=%0d berr=%b ret=%0d expected st=0 berr=0 ret=1", st_a, berr_a, ret_a); end
  endtask

  task automatic test_illegal();
    logic [5:0] ops [9] = '{OP_R, OP_R, OP_R, OP_R, OP_BAD, OP_BAD, OP_BAD, OP_BAD, OP_BAD};
    drive(0, 1'b1, OP_R, 1'b0); advance(0);
    for (int i = 0; i < 9; i++) begin
      drive(0, 1'b0, ops[i], (i == 0 || i == 4) ? 1'b1 : 1'($urandom));
      checks++; if (obs(0) !== expv(0)) begin errors++; $display("FAIL ill_cyc%0d: got %h expected %h", i, obs(0), expv(0)); end
      advance(0);
    end
    checks++; if ({st_a, ill_a, berr_a, ret_a} !== {4'd13, 1'b1, 1'b0, 32'd1}) begin
      errors++; $display("FAIL ill_trap: got st=%0d ill=%b berr=%b ret=%0d expected st=13 ill=1 berr=0 ret=1", st_a, ill_a, berr_a, ret_a); end
    drive(0, 1'b1, OP_R, 1'b0); advance(0);
    drive(0, 1'b0, OP_R, 1'b0);
    checks++; if ({st_a, ill_a, berr_a} !== 6'd0) begin
      errors++; $display("FAIL ill_clear: got st=%0d ill=%b berr=%b expected 0 0 0", st_a, ill_a, berr_a); end
    advance(0);
  endtask

  task automatic test_branch();
    logic [5:0] ops [7] = '{OP_BNE, OP_BNE, OP_BNE, OP_BEQ, OP_BEQ, OP_BEQ, OP_R};
    int seen_ne = 0, seen_eq = 0;
    drive(0, 1'b1, OP_R, 1'b0); advance(0);
    for (int i = 0; i < 7; i++) begin
      drive(0, 1'b0, ops[i], 1'b1);
      checks++; if (obs(0) !== expv(0)) begin errors++; $display("FAIL br_cyc%0d: got %h expected %h", i, obs(0), expv(0)); end
      if (st_a == 4'd8 && aop_a == 2'b01 && psrc_a == 2'b01) begin
        if (pcne_a === 1'b1 && pcc_a === 1'b0 && i == 2) seen_ne++;
        if (pcc_a === 1'b1 && pcne_a === 1'b0 && i == 5) seen_eq++;
      end
      advance(0);
    end
    checks++; if (seen_ne != 1) begin errors++; $display("FAIL br_bne: got %0d expected 1", seen_ne); end
    checks++; if (seen_eq != 1) begin errors++; $display("FAIL br_beq: got %0d expected 1", seen_eq); end
    checks++; if (ret_a !== 32'd2) begin errors++; $display("FAIL br_retired: got %0d expected 2", ret_a); end
  endtask

  task automatic test_jal();
    drive(0, 1'b1, OP_R, 1'b0); advance(0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, OP_JAL, 1'b1);
      checks++; if (obs(0) !== expv(0)) begin errors++; $display("FAIL jal_cyc%0d: got %h expected %h", i, obs(0), expv(0)); end
      if (i == 2) begin
        checks++; if ({st_a, pcw_a, rw_a, rdst_a, m2r_a, psrc_a} !== {4'd12, 1'b1, 1'b1, 2'b10, 2'b10, 2'b10}) begin
          errors++; $display("FAIL jal_ctl: got st=%0d pcw=%b rw=%b rd=%b m2r=%b ps=%b expected 12 1 1 10 10 10", st_a, pcw_a, rw_a, rdst_a, m2r_a, psrc_a); end
      end
      advance(0);
    end
    checks++; if (ret_a !== 32'd1) begin errors++; $display("FAIL jal_retired: got %0d expected 1", ret_a); end
  endtask

  task automatic test_wrap();
    int fetch_cyc = 0;
    bit saw15 = 0;
    drive(1, 1'b1, OP_R, 1'b0); advance(1);
    for (int i = 0; i < 64; i++) begin
      drive(1, 1'b0, OP_R, 1'($urandom));
      checks++; if (obs(1) !== expv(1)) begin errors++; $display("FAIL wrap_cyc%0d: got %h expected %h", i, obs(1), expv(1)); end
      checks++; if (oret(1) !== eret(1)) begin errors++; $display("FAIL wrap_ret%0d: got %0d expected %0d", i, oret(1), eret(1)); end
      if (st_b == 4'd0) fetch_cyc++;
      if (ret_b == 4'd15) saw15 = 1;
      advance(1);
    end
    checks++; if (fetch_cyc != 16) begin errors++; $display("FAIL wrap_fetches: got %0d expected 16", fetch_cyc); end
    checks++; if (!(saw15 && ret_b === 4'd0)) begin errors++; $display("FAIL wrap_count: got ret=%0d saw15=%0d expected 0 and 1", ret_b, saw15); end
    for (int i = 0; i < 3; i++) begin drive(1, 1'b0, OP_SW, 1'b0); advance(1); end
    drive(1, 1'b1, OP_SW, 1'b1);
    checks++; if ({st_b, mwr_b} !== {4'd5, 1'b0}) begin errors++; $display("FAIL rst_memwr: got st=%0d mw=%b expected st=5 mw=0", st_b, mwr_b); end
    advance(1);
    drive(1, 1'b0, OP_SW, 1'b0);
    checks++; if ({st_b, mwr_b} !== {4'd0, 1'b0}) begin errors++; $display("FAIL rst_after: got st=%0d mw=%b expected st=0 mw=0", st_b, mwr_b); end
    advance(1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      logic [5:0] opc = OP_R;
      int         trap_cyc = 0;
      logic       rst;
      drive(k, 1'b1, opc, 1'b0); advance(k);
      for (int i = 0; i < ((k == 0) ? 900 : 300); i++) begin
        if (!m_trap[k] && m_pos[k] == 0) opc = pick_op();
        rst = (trap_cyc >= 3) || ($urandom_range(0, 149) == 0);
        drive(k, rst, opc, ($urandom_range(0, 9) < 6));
        checks++; if (obs(k) !== expv(k)) begin errors++; $display("FAIL rnd%0d_cyc%0d: got %h expected %h", k, i, obs(k), expv(k)); end
        checks++; if (oret(k) !== eret(k)) begin errors++; $display("FAIL rnd%0d_ret%0d: got %0d expected %0d", k, i, oret(k), eret(k)); end
        advance(k);
        trap_cyc = m_trap[k] ? trap_cyc + 1 : 0;
      end
    end
  endtask

  initial begin
    tbl[0]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 2'd0, 2'd0);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0);
    tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd2, 2'd0);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 2'd1, 2'd1);
    tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2);
    tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 2'd2, 2'd0, 2'd0);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2);
    tbl[13] = 19'd0;
    rst_a = 1'b1; opc_a = OP_R; mr_a = 1'b0;
    rst_b = 1'b1; opc_b = OP_R; mr_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cur_rst[k] = 1'b1; cur_opc[k] = OP_R; cur_mr[k] = 1'b0;
      model_reset(k);
    end
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lw_wait();
    test_timeout();
    test_illegal();
    test_branch();
    test_jal();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
